// File: rtl/t06_lcd_pkg.sv
// Shared definitions for the 16x2 character-LCD text path: command and state
// encodings, character constants and row geometry.
package t06_lcd_pkg;

    localparam int ROWS       = 2;
    localparam int COLS       = 16;
    localparam int CHAR_W     = 8;
    localparam int ROW_W      = COLS * CHAR_W;
    localparam int COL_W      = 4;
    localparam int BIN_W      = 16;
    localparam int NUM_DIGITS = 5;
    localparam int BCD_W      = NUM_DIGITS * 4;

    localparam logic [CHAR_W-1:0] BLANK_CHAR = 8'h20;
    localparam logic [CHAR_W-1:0] ASCII_ZERO = 8'h30;

    typedef enum logic [1:0] {
        OP_WRITE_CHAR = 2'd0,
        OP_WRITE_NUM  = 2'd1,
        OP_CLEAR_ROW  = 2'd2,
        OP_CLEAR_ALL  = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    // Column 0 is the most significant byte, matching the driver's row layout.
    typedef logic [0:COLS-1][CHAR_W-1:0] row_t;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/t06_bin2bcd16.sv
// Sequential double-dabble converter: 16-bit binary to 5 BCD digits, one shift
// per cycle, 16 cycles from start to done.
module t06_bin2bcd16
    import t06_lcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    logic [BIN_W-1:0]       bin_q;
    logic [3:0]             step_q;
    logic                   running_q;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+BIN_W-1:0] shifted;

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            bcd_adj[4*i +: 4] = add3(bcd[4*i +: 4]);
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    // done stays high after the last shift until the next start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_q     <= '0;
            bcd       <= '0;
            step_q    <= '0;
            running_q <= 1'b0;
            done      <= 1'b0;
        end else if (start) begin
            bin_q     <= bin;
            bcd       <= '0;
            step_q    <= '0;
            running_q <= 1'b1;
            done      <= 1'b0;
        end else if (running_q) begin
            bcd    <= shifted[BCD_W+BIN_W-1:BIN_W];
            bin_q  <= shifted[BIN_W-1:0];
            step_q <= step_q + 4'd1;
            if (step_q == 4'd15) begin
                running_q <= 1'b0;
                done      <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/t06_lcd_text_buffer.sv
// Two-row character frame buffer with a command port for character writes,
// row/screen clears and right-aligned 5-digit decimal printing.
module t06_lcd_text_buffer
    import t06_lcd_pkg::*;
#(
    parameter logic [CHAR_W-1:0] BLANK    = BLANK_CHAR,
    parameter bit                ZERO_PAD = 1'b0
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_row,
    input  logic [COL_W-1:0] cmd_col,
    input  logic [15:0]      cmd_data,
    output logic             busy,
    output logic [ROW_W-1:0] row_1,
    output logic [ROW_W-1:0] row_2
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // the caller holds cmd_valid and all cmd_* fields stable until then.

    state_e             state;
    row_t               rows_q [ROWS];
    logic               row_q;
    logic [COL_W-1:0]   col_q;
    logic [3:0]         conv_cnt;
    logic [2:0]         emit_cnt;
    logic               seen_nz;

    cmd_op_e            op;
    logic               accept;
    logic               conv_start;
    logic               conv_done;
    logic [BCD_W-1:0]   conv_bcd;
    logic [3:0]         emit_nib;
    logic [COL_W:0]     emit_col;
    logic [CHAR_W-1:0]  emit_char;
    logic [CHAR_W-1:0]  pad_char;

    assign op         = cmd_op_e'(cmd_op);
    assign cmd_ready  = (state == ST_IDLE);
    assign busy       = !cmd_ready;
    assign accept     = cmd_valid && cmd_ready;
    assign conv_start = accept && (op == OP_WRITE_NUM);
    assign row_1      = rows_q[0];
    assign row_2      = rows_q[1];

    t06_bin2bcd16 u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (cmd_data),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    always_comb begin
        case (emit_cnt)
            3'd0:    emit_nib = conv_bcd[19:16];
            3'd1:    emit_nib = conv_bcd[15:12];
            3'd2:    emit_nib = conv_bcd[11:8];
            3'd3:    emit_nib = conv_bcd[7:4];
            default: emit_nib = conv_bcd[3:0];
        endcase
        pad_char = ZERO_PAD ? ASCII_ZERO : BLANK;
        emit_col = {1'b0, col_q} + {2'b00, emit_cnt};
        // Units digit always prints so that zero shows as "    0".
        if (emit_nib == 4'd0 && !seen_nz && emit_cnt != 3'd4) begin
            emit_char = pad_char;
        end else begin
            emit_char = ASCII_ZERO + {4'd0, emit_nib};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            row_q    <= 1'b0;
            col_q    <= '0;
            conv_cnt <= '0;
            emit_cnt <= '0;
            seen_nz  <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                rows_q[r] <= {COLS{BLANK}};
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_WRITE_CHAR: rows_q[cmd_row][cmd_col] <= cmd_data[7:0];
                            OP_WRITE_NUM: begin
                                row_q    <= cmd_row;
                                col_q    <= cmd_col;
                                conv_cnt <= '0;
                                emit_cnt <= '0;
                                seen_nz  <= 1'b0;
                                state    <= ST_CONV;
                            end
                            OP_CLEAR_ROW:  rows_q[cmd_row] <= {COLS{BLANK}};
                            default: begin
                                rows_q[0] <= {COLS{BLANK}};
                                rows_q[1] <= {COLS{BLANK}};
                            end
                        endcase
                    end
                end
                ST_CONV: begin
                    conv_cnt <= conv_cnt + 4'd1;
                    if (conv_cnt == 4'd15) begin
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    // Digits past column 15 are clocked through but not written.
                    if (conv_done && !emit_col[COL_W]) begin
                        rows_q[row_q][emit_col[COL_W-1:0]] <= emit_char;
                    end
                    if (emit_nib != 4'd0) begin
                        seen_nz <= 1'b1;
                    end
                    emit_cnt <= emit_cnt + 3'd1;
                    if (emit_cnt == 3'd4) begin
                        emit_cnt <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t06_lcd_text_buffer.sv
// Bench for the LCD text buffer: a reference text model feeds expected row
// images into a queue that is compared once each command has completed.
module tb_t06_lcd_text_buffer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'd0;
    logic         cmd_row = 1'b0;
    logic [3:0]   cmd_col = 4'd0;
    logic [15:0]  cmd_data = 16'd0;
    logic         busy;
    logic [127:0] row_1;
    logic [127:0] row_2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] model_r [2];
    logic [255:0] exp_q [$];
    logic [255:0] exp_v;

    localparam logic [127:0] BLANK_ROW = {16{8'h20}};

    t06_lcd_text_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .cmd_data  (cmd_data),
        .busy      (busy),
        .row_1     (row_1),
        .row_2     (row_2)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- model ----------------
    function automatic void model_clear();
        model_r[0] = BLANK_ROW;
        model_r[1] = BLANK_ROW;
    endfunction

    function automatic void model_char(input int row, input int col, input logic [7:0] ch);
        model_r[row][127 - 8*col -: 8] = ch;
    endfunction

    function automatic void model_num(input int row, input int col, input int val);
        int d [5];
        int v;
        bit nz;
        logic [7:0] ch;
        v  = val;
        nz = 1'b0;
        for (int k = 4; k >= 0; k--) begin
            d[k] = v % 10;
            v    = v / 10;
        end
        for (int k = 0; k < 5; k++) begin
            if (d[k] != 0) nz = 1'b1;
            ch = (!nz && k != 4) ? 8'h20 : 8'h30 + 8'(d[k]);
            if (col + k <= 15) model_r[row][127 - 8*(col+k) -: 8] = ch;
        end
    endfunction

    function automatic void push_expected();
        exp_q.push_back({model_r[0], model_r[1]});
    endfunction

    // ---------------- driver ----------------
    task automatic drive_cmd(input logic [1:0] op, input logic row, input logic [3:0] col,
                             input logic [15:0] data);
        int n;
        cmd_op = op; cmd_row = row; cmd_col = col; cmd_data = data; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        n_checks++;
        if (!cmd_ready) $display("FAIL accept_timeout: cmd_ready=%0b required 1", cmd_ready);
        else n_pass++;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        n_checks++;
        if (!cmd_ready) $display("FAIL done_timeout: cmd_ready=%0b required 1", cmd_ready);
        else n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        model_clear();
        n_checks++;
        if ({row_1, row_2} !== {BLANK_ROW, BLANK_ROW})
            $display("FAIL reset_rows: rows=%h required %h", {row_1, row_2}, {BLANK_ROW, BLANK_ROW});
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_ready: ready=%0b busy=%0b required 1/0", cmd_ready, busy);
        else n_pass++;
        @(negedge clk) rst = 1'b1;
        tick();
        // Dirty the screen and start a conversion, then reset between edges.
        drive_cmd(2'd0, 1'b0, 4'd5, 16'h0041);
        cmd_op = 2'd1; cmd_row = 1'b1; cmd_col = 4'd0; cmd_data = 16'd4321; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({row_1, row_2} !== {BLANK_ROW, BLANK_ROW})
            $display("FAIL async_reset_rows: rows=%h required %h", {row_1, row_2}, {BLANK_ROW, BLANK_ROW});
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL async_reset_ready: ready=%0b busy=%0b required 1/0", cmd_ready, busy);
        else n_pass++;
        @(negedge clk) rst = 1'b1;
        tick();
    endtask

    task automatic test_write_char();
        cmd_op = 2'd0; cmd_row = 1'b0; cmd_col = 4'd0; cmd_data = 16'h0048; cmd_valid = 1'b1;
        tick();
        model_char(0, 0, 8'h48);
        push_expected();
        n_checks++;
        if (row_1[127:120] !== 8'h48 || cmd_ready !== 1'b1)
            $display("FAIL char_h: byte=%h ready=%0b required 48/1", row_1[127:120], cmd_ready);
        else n_pass++;
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({row_1, row_2} !== exp_v) $display("FAIL char_h_rows: rows=%h required %h", {row_1, row_2}, exp_v);
        else n_pass++;
        cmd_row = 1'b1; cmd_col = 4'd15; cmd_data = 16'h0021;
        tick();
        cmd_valid = 1'b0;
        model_char(1, 15, 8'h21);
        push_expected();
        n_checks++;
        if (row_2[7:0] !== 8'h21 || cmd_ready !== 1'b1)
            $display("FAIL char_bang: byte=%h ready=%0b required 21/1", row_2[7:0], cmd_ready);
        else n_pass++;
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({row_1, row_2} !== exp_v) $display("FAIL char_bang_rows: rows=%h required %h", {row_1, row_2}, exp_v);
        else n_pass++;
    endtask

    task automatic test_write_num();
        logic [7:0] exp_dig [5];
        logic [7:0] held_byte;
        int low_cnt;
        int dig_bad;
        int held_bad;
        exp_dig = '{8'h20, 8'h31, 8'h32, 8'h33, 8'h34};
        model_num(0, 3, 1234);
        push_expected();
        cmd_op = 2'd1; cmd_row = 1'b0; cmd_col = 4'd3; cmd_data = 16'd1234; cmd_valid = 1'b1;
        tick();
        // Queue a character write behind the number; it must wait.
        held_byte = model_r[1][127:120];
        cmd_op = 2'd0; cmd_row = 1'b1; cmd_col = 4'd0; cmd_data = 16'h005A;
        low_cnt = 0; dig_bad = 0; held_bad = 0;
        for (int n = 0; n < 40; n++) begin
            if (n >= 17 && n <= 21 && row_1[127 - 8*(3 + n - 17) -: 8] !== exp_dig[n-17]) dig_bad++;
            if (cmd_ready) break;
            if (row_2[127:120] !== held_byte) held_bad++;
            low_cnt++;
            tick();
        end
        n_checks++;
        if (low_cnt !== 21) $display("FAIL num_busy_len: cycles=%0d required 21", low_cnt);
        else n_pass++;
        n_checks++;
        if (dig_bad !== 0) $display("FAIL num_digit_timing: bad=%0d required 0", dig_bad);
        else n_pass++;
        n_checks++;
        if (held_bad !== 0) $display("FAIL num_holdoff: bad=%0d required 0", held_bad);
        else n_pass++;
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({row_1, row_2} !== exp_v) $display("FAIL num_1234_rows: rows=%h required %h", {row_1, row_2}, exp_v);
        else n_pass++;
        tick();
        cmd_valid = 1'b0;
        model_char(1, 0, 8'h5A);
        push_expected();
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({row_1, row_2} !== exp_v) $display("FAIL held_char_rows: rows=%h required %h", {row_1, row_2}, exp_v);
        else n_pass++;
    endtask

    task automatic test_num_edges();
        int low_cnt;
        model_num(1, 13, 65535);
        push_expected();
        cmd_op = 2'd1; cmd_row = 1'b1; cmd_col = 4'd13; cmd_data = 16'd65535; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        low_cnt = 0;
        while (!cmd_ready && low_cnt < 40) begin low_cnt++; tick(); end
        n_checks++;
        if (low_cnt !== 21) $display("FAIL overflow_busy_len: cycles=%0d required 21", low_cnt);
        else n_pass++;
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({row_1, row_2} !== exp_v) $display("FAIL overflow_rows: rows=%h required %h", {row_1, row_2}, exp_v);
        else n_pass++;
        model_num(0, 0, 0);
        push_expected();
        drive_cmd(2'd1, 1'b0, 4'd0, 16'd0);
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({row_1, row_2} !== exp_v) $display("FAIL zero_rows: rows=%h required %h", {row_1, row_2}, exp_v);
        else n_pass++;
    endtask

    task automatic test_random_nums();
        int row, col, val;
        for (int i = 0; i < 5; i++) begin
            row = $urandom_range(0, 1);
            col = $urandom_range(0, 15);
            val = $urandom_range(0, 65535) >> $urandom_range(0, 15);
            model_num(row, col, val);
            push_expected();
            drive_cmd(2'd1, row[0], col[3:0], val[15:0]);
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({row_1, row_2} !== exp_v)
                $display("FAIL rand_num_%0d (v=%0d r=%0d c=%0d): rows=%h required %h", i, val, row, col, {row_1, row_2}, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_clear();
        int row, col;
        logic [7:0] ch;
        for (int i = 0; i < 8; i++) begin
            row = i % 2;
            col = $urandom_range(0, 15);
            ch  = 8'($urandom_range(8'h41, 8'h7A));
            model_char(row, col, ch);
            drive_cmd(2'd0, row[0], col[3:0], {8'h00, ch});
        end
        push_expected();
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({row_1, row_2} !== exp_v) $display("FAIL fill_rows: rows=%h required %h", {row_1, row_2}, exp_v);
        else n_pass++;
        model_r[1] = BLANK_ROW;
        push_expected();
        drive_cmd(2'd2, 1'b1, 4'd0, 16'd0);
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({row_1, row_2} !== exp_v) $display("FAIL clear_row_rows: rows=%h required %h", {row_1, row_2}, exp_v);
        else n_pass++;
        model_clear();
        push_expected();
        drive_cmd(2'd3, 1'b0, 4'd0, 16'd0);
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({row_1, row_2} !== exp_v) $display("FAIL clear_all_rows: rows=%h required %h", {row_1, row_2}, exp_v);
        else n_pass++;
    endtask

    task automatic test_reset_mid_conv();
        int blank_bad;
        drive_cmd(2'd0, 1'b0, 4'd2, 16'h0051);
        cmd_op = 2'd1; cmd_row = 1'b0; cmd_col = 4'd0; cmd_data = 16'd999; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if ({row_1, row_2} !== {BLANK_ROW, BLANK_ROW} || cmd_ready !== 1'b1)
            $display("FAIL midconv_reset: rows=%h ready=%0b required blank/1", {row_1, row_2}, cmd_ready);
        else n_pass++;
        @(negedge clk) rst = 1'b1;
        blank_bad = 0;
        for (int n = 0; n < 25; n++) begin
            tick();
            if ({row_1, row_2} !== {BLANK_ROW, BLANK_ROW} || cmd_ready !== 1'b1) blank_bad++;
        end
        n_checks++;
        if (blank_bad !== 0) $display("FAIL midconv_discard: bad=%0d required 0", blank_bad);
        else n_pass++;
        model_char(1, 7, 8'h6B);
        push_expected();
        drive_cmd(2'd0, 1'b1, 4'd7, 16'h006B);
        exp_v = exp_q.pop_front();
        n_checks++;
        if ({row_1, row_2} !== exp_v) $display("FAIL post_reset_char: rows=%h required %h", {row_1, row_2}, exp_v);
        else n_pass++;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        model_clear();
        test_reset();
        test_write_char();
        test_write_num();
        test_num_edges();
        test_random_nums();
        test_clear();
        test_reset_mid_conv();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/t06_lcd_text_buffer.md
# t06_lcd_text_buffer

Character frame buffer and number formatter that sits directly upstream of the team's 16x2 character-LCD driver. It stores two 16-character ASCII rows and presents them continuously as `row_1`/`row_2` (128 bits each) for the driver to refresh. Game logic issues simple commands over a valid/ready port: write one character, print a 16-bit unsigned number in decimal, clear a row, or clear the screen. Decimal conversion is done sequentially by shift-add-3 (double dabble).

## Interface
Parameters:
- `BLANK`, 8'h20, fill character used on reset, on clear and for suppressed leading zeros.
- `ZERO_PAD`, 0, when 1 leading zeros are printed as '0' (8'h30) instead of `BLANK`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `cmd_op`  in  2  0 = WRITE_CHAR, 1 = WRITE_NUM, 2 = CLEAR_ROW, 3 = CLEAR_ALL.
- `cmd_row`  in  1  0 = row_1, 1 = row_2.
- `cmd_col`  in  4  column index 0..15.
- `cmd_data`  in  16  [7:0] is the character for WRITE_CHAR; all 16 bits are the value for WRITE_NUM.
- `busy`  out  1  equal to `!cmd_ready`.
- `row_1`  out  128  row 1 text; column c occupies bits [127-8c -: 8].
- `row_2`  out  128  row 2 text, same layout.

## Operation
- States and transitions:
  - IDLE: the only state in which `cmd_ready` is 1.
  - CONV: 16 cycles of BCD conversion.
  - EMIT: 5 cycles, one decimal digit written per cycle.
- A command is accepted on a rising edge with `cmd_valid && cmd_ready`. Command fields are sampled only at acceptance.
- WRITE_CHAR: the target byte is updated on the accepting edge. State stays IDLE.
- CLEAR_ROW: all 16 bytes of the selected row become `BLANK` on the accepting edge.
- CLEAR_ALL: both rows become `BLANK` on the accepting edge.
- WRITE_NUM:
  - Latch `row`, `col` and `value`, then go to CONV.
  - CONV runs 16 shift steps of double dabble into a 20-bit BCD register (5 digits, 0..65535). Before each shift, add 3 to every nibble that is ≥5.
  - EMIT writes digits most significant first, to columns col, col+1, …, col+4.
  - Digit ASCII is 8'h30 + nibble.
  - Leading zeros: every digit before the first nonzero digit becomes `BLANK` (or '0' if `ZERO_PAD`=1). The last digit is always printed, so value 0 gives "    0".
  - Column overflow: a column index above 15 suppresses that write. There is no wrap to the next row, and the remaining digits are still clocked through EMIT.
- Commands presented while busy are held off by `cmd_ready`=0. A caller must hold `cmd_valid` and its fields until accepted.
- Asynchronous reset, including mid-conversion:
  - state → IDLE, counters → 0, BCD register → 0.
  - `row_1` and `row_2` → all `BLANK` (16 × `BLANK`).
  - `cmd_ready` → 1, `busy` → 0.
  - Any in-flight WRITE_NUM is discarded.

## Timing
- WRITE_CHAR, CLEAR_ROW, CLEAR_ALL: single-cycle. Visible on `row_x` immediately after the accepting edge. Back-to-back acceptance is allowed every cycle.
- WRITE_NUM, with the accepting edge as edge 0:
  - Edges 1–16: CONV.
  - Edges 17–21: EMIT, with digit k (k = 0..4) visible after edge 17+k.
  - Edge 21 also returns the state to IDLE, so `cmd_ready` is 1 in the cycle after edge 21.
  - `cmd_ready` is 0 for exactly 21 cycles.
- `row_1`/`row_2` are registered outputs with no combinational path from `cmd_*`. The downstream driver may sample them at any time. Partially printed numbers are visible during EMIT, which is acceptable.

## Structure
- Shared package `t06_lcd_pkg` holds:
  - the `cmd_op` encodings (WRITE_CHAR, WRITE_NUM, CLEAR_ROW, CLEAR_ALL);
  - the state encoding (IDLE, CONV, EMIT);
  - the default `BLANK`, the ASCII zero offset 8'h30 and the row/column width constants.
  The LCD driver also imports this package.
- One natural sub-module is `t06_bin2bcd16`: a start/done sequential double dabble, 16-bit in, 20-bit BCD out, 16 cycles. The parent sequences the start and the EMIT writes.

## Test plan
- Reset: assert `rst`=0 mid-sim → `row_1` = `row_2` = {16{8'h20}}, `cmd_ready`=1 asynchronously, before the next clock edge.
- WRITE_CHAR row 0 col 0 'H' (8'h48), then row 1 col 15 '!' (8'h21) on consecutive cycles → `row_1[127:120]`=8'h48 and `row_2[7:0]`=8'h21, each one edge after acceptance; `cmd_ready` stays 1.
- WRITE_NUM value 1234, row 0, col 3, `ZERO_PAD`=0 → cols 3..7 = 8'h20,8'h31,8'h32,8'h33,8'h34; `cmd_ready` low for exactly 21 cycles; a new `cmd_valid` during busy is not accepted until ready returns.
- WRITE_NUM 65535 at col 13 → cols 13..15 = "655"; nothing else changes in either row; state returns to IDLE at edge 21. Value 0 at col 0 → "    0".
- CLEAR_ROW row 1 after filling both rows → `row_2` all 8'h20 and `row_1` unchanged. CLEAR_ALL → both rows blank.
- Assert `rst` low at edge 10 of a WRITE_NUM → rows all blank and IDLE; a subsequent WRITE_CHAR is accepted and correct.
